// File: rtl/step_input_conditioner.sv
// Step/direction input conditioner: synchronise and debounce raw pads, emit a one-shot step strobe.
// Define AUTO_REPEAT_EN to add hold-to-repeat step pulses.
module step_input_conditioner #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DB_CYCLES    = 16,
    parameter int unsigned REPEAT_DELAY = 256,
    parameter int unsigned REPEAT_RATE  = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_step_in,
    input  logic btn_dir_in,
    output logic step_pulse,
    output logic dir_up,
    output logic step_held
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DB_CYCLES < 2 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("step_input_conditioner: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] step_sync_q;
    logic [SYNC_STAGES-1:0] dir_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_sync_q <= '0;
            dir_sync_q  <= '0;
        end else begin
            step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], btn_step_in};
            dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], btn_dir_in};
        end
    end

    // Index 0 is the step button, index 1 the direction switch.
    logic [1:0]            sync_out;
    logic [1:0]            stable_q, stable_d;
    logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

    assign sync_out = {dir_sync_q[SYNC_STAGES-1], step_sync_q[SYNC_STAGES-1]};

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_out[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
                stable_d[i] = sync_out[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            db_cnt_q <= '0;
        end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    logic step_stable;
    assign step_stable = stable_q[0];
    assign dir_up      = stable_q[1];

`ifdef AUTO_REPEAT_EN
    typedef enum logic [1:0] {StIdle, StFire, StHeld, StRepeat} state_e;

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`else
    typedef enum logic [1:0] {StIdle, StFire, StHeld} state_e;
`endif

    state_e state_q, state_d;
    logic   pulse_d;
    logic   step_pulse_q, step_held_q;

    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        unique case (state_q)
            StIdle: if (step_stable) state_d = StFire;
            StFire: state_d = step_stable ? StHeld : StIdle;
`ifdef AUTO_REPEAT_EN
            StHeld: begin
                if (!step_stable) begin
                    state_d = StIdle;
                end else if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                    state_d = StRepeat;
                end
            end
            StRepeat: begin
                if (!step_stable) begin
                    state_d = StIdle;
                end else if (rpt_cnt_q == RPT_W'(REPEAT_RATE - 1)) begin
                    pulse_d = 1'b1;
                end
            end
`else
            StHeld: if (!step_stable) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
        if (state_d == StFire) pulse_d = 1'b1;
    end

`ifdef AUTO_REPEAT_EN
    // One counter serves both the hold delay and the repeat period; any state change restarts it.
    always_comb begin
        rpt_cnt_d = '0;
        if (state_d == state_q) begin
            if (state_q == StHeld) begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end else if (state_q == StRepeat && rpt_cnt_q != RPT_W'(REPEAT_RATE - 1)) begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rpt_cnt_q <= '0;
        else        rpt_cnt_q <= rpt_cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            step_pulse_q <= 1'b0;
            step_held_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_pulse_q <= pulse_d;
            step_held_q  <= (state_d != StIdle);
        end
    end

    assign step_pulse = step_pulse_q;
    assign step_held  = step_held_q;

endmodule
